// File: rtl/cv32e40p_ft_pkg.sv
// Shared types for the fault-tolerance voter error monitor: FSM states,
// replica identifiers and small bit-vector helpers.
package cv32e40p_ft_pkg;

    localparam int REPLICAS = 3;

    typedef enum logic [1:0] {
        MONITOR  = 2'd0,
        REPORT   = 2'd1,
        DEGRADED = 2'd2,
        FATAL    = 2'd3
    } mon_state_e;

    typedef logic [1:0] replica_id_t;

    // Replica numbering is 1-based; the lowest-numbered set bit wins.
    function automatic replica_id_t first_set_id(input logic [REPLICAS-1:0] v);
        replica_id_t id;
        id = '0;
        for (int k = REPLICAS - 1; k >= 0; k--) begin
            if (v[k]) begin
                id = replica_id_t'(k + 1);
            end
        end
        return id;
    endfunction

    function automatic logic [1:0] count_ones(input logic [REPLICAS-1:0] v);
        logic [1:0] n;
        n = '0;
        for (int k = 0; k < REPLICAS; k++) begin
            n = n + {1'b0, v[k]};
        end
        return n;
    endfunction

endpackage

// File: rtl/cv32e40p_sat_updown_counter.sv
// Saturating up/down counter: simultaneous inc and dec cancel, increments
// stop at all-ones, decrements stop at zero.
module cv32e40p_sat_updown_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] MAX_CNT = '1;

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (en_i) begin
            if (inc_i && !dec_i && (r_cnt != MAX_CNT)) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (dec_i && !inc_i && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/cv32e40p_voter_err_monitor.sv
// Per-replica leaky error counting behind the 3-way voter, faulty-replica
// declaration with a req/ack report, and a sticky fatal flag.
module cv32e40p_voter_err_monitor
    import cv32e40p_ft_pkg::*;
#(
    parameter int  CNT_W        = 8,
    parameter int  THRESHOLD    = 16,
    parameter int  DECAY_WINDOW = 1024,
    localparam int WIN_W        = $clog2(DECAY_WINDOW)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear_i,
    input  logic                        vote_valid_i,
    input  logic                        err_detected_1_i,
    input  logic                        err_detected_2_i,
    input  logic                        err_detected_3_i,
    input  logic                        irq_ack_i,
    output logic [REPLICAS*CNT_W-1:0]   err_cnt_o,
    output logic [REPLICAS-1:0]         faulty_o,
    output logic [1:0]                  fault_id_o,
    output logic                        irq_req_o,
    output logic                        fatal_o
);

    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(DECAY_WINDOW - 1);
    localparam logic [CNT_W:0]   THR_EXT  = (CNT_W+1)'(THRESHOLD);

    mon_state_e          r_state;
    mon_state_e          w_state_nxt;
    logic [WIN_W-1:0]    r_win;
    logic [REPLICAS-1:0] r_faulty;
    replica_id_t         r_fault_id;
    replica_id_t         w_fault_id_nxt;
    logic                r_irq;
    logic                w_irq_nxt;
    logic                r_fatal;

    logic                w_run;
    logic                w_dec_tick;
    logic [REPLICAS-1:0] w_err;
    logic [REPLICAS-1:0] w_inc;
    logic                w_unc;
    logic [REPLICAS-1:0] w_newly;
    logic [1:0]          w_n_newly;
    logic [CNT_W-1:0]    w_cnt [REPLICAS];

    // Everything that ages or counts stops once the monitor has gone fatal.
    assign w_run      = (r_state != FATAL);
    assign w_dec_tick = w_run && (r_win == WIN_LAST);
    assign w_err      = {err_detected_3_i, err_detected_2_i, err_detected_1_i};
    assign w_inc      = {REPLICAS{vote_valid_i}} & w_err & ~r_faulty;
    assign w_unc      = vote_valid_i & (&w_err);

    for (genvar k = 0; k < REPLICAS; k++) begin : g_rep
        cv32e40p_sat_updown_counter #(
            .W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr_i (clear_i),
            .en_i  (w_run & ~r_faulty[k]),
            .inc_i (w_inc[k]),
            .dec_i (w_dec_tick),
            .cnt_o (w_cnt[k])
        );

        // Only a net increment can lift a healthy count onto the threshold;
        // a saturated count stays at all-ones, which is still >= THRESHOLD.
        assign w_newly[k] = w_run & w_inc[k] & ~w_dec_tick &
                            (({1'b0, w_cnt[k]} + 1'b1) >= THR_EXT);

        assign err_cnt_o[k*CNT_W +: CNT_W] = w_cnt[k];
    end

    assign w_n_newly = count_ones(w_newly);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_win <= '0;
        end else if (clear_i) begin
            r_win <= '0;
        end else if (w_run) begin
            r_win <= (r_win == WIN_LAST) ? '0 : r_win + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_fault_id_nxt = r_fault_id;
        w_irq_nxt      = r_irq & ~irq_ack_i;
        unique case (r_state)
            MONITOR: begin
                if (w_unc || (w_n_newly >= 2'd2)) begin
                    w_state_nxt = FATAL;
                end else if (w_n_newly == 2'd1) begin
                    w_state_nxt    = REPORT;
                    w_fault_id_nxt = first_set_id(w_newly);
                    w_irq_nxt      = 1'b1;
                end
            end
            REPORT: begin
                if (w_unc || (w_n_newly != 2'd0)) begin
                    w_state_nxt = FATAL;
                end else if (irq_ack_i) begin
                    w_state_nxt = DEGRADED;
                end
            end
            DEGRADED: begin
                if (w_n_newly != 2'd0) begin
                    w_state_nxt    = FATAL;
                    w_fault_id_nxt = first_set_id(w_newly);
                    w_irq_nxt      = 1'b1;
                end else if (w_unc) begin
                    w_state_nxt = FATAL;
                end
            end
            FATAL: begin
                w_state_nxt = FATAL;
            end
            default: begin
                w_state_nxt = MONITOR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            r_state    <= MONITOR;
            r_faulty   <= '0;
            r_fault_id <= '0;
            r_irq      <= 1'b0;
            r_fatal    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_faulty   <= r_faulty | w_newly;
            r_fault_id <= w_fault_id_nxt;
            r_irq      <= w_irq_nxt;
            r_fatal    <= (w_state_nxt == FATAL);
        end
    end

    assign faulty_o   = r_faulty;
    assign fault_id_o = r_fault_id;
    assign irq_req_o  = r_irq;
    assign fatal_o    = r_fatal;

endmodule

// File: tb/tb_cv32e40p_voter_err_monitor.sv
// Randomized + directed scoreboard bench for cv32e40p_voter_err_monitor
// with CNT_W=4, THRESHOLD=4, DECAY_WINDOW=8.
module tb_cv32e40p_voter_err_monitor;

    localparam int CW   = 4;
    localparam int TH   = 4;
    localparam int DW   = 8;
    localparam int MAXC = (1 << CW) - 1;

    localparam int ST_MON = 0;
    localparam int ST_REP = 1;
    localparam int ST_DEG = 2;
    localparam int ST_FAT = 3;

    logic            clk;
    logic            rst_n;
    logic            clear_i;
    logic            vote_valid_i;
    logic            err1, err2, err3;
    logic            irq_ack_i;
    logic [3*CW-1:0] err_cnt_o;
    logic [2:0]      faulty_o;
    logic [1:0]      fault_id_o;
    logic            irq_req_o;
    logic            fatal_o;

    cv32e40p_voter_err_monitor #(
        .CNT_W        (CW),
        .THRESHOLD    (TH),
        .DECAY_WINDOW (DW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .clear_i          (clear_i),
        .vote_valid_i     (vote_valid_i),
        .err_detected_1_i (err1),
        .err_detected_2_i (err2),
        .err_detected_3_i (err3),
        .irq_ack_i        (irq_ack_i),
        .err_cnt_o        (err_cnt_o),
        .faulty_o         (faulty_o),
        .fault_id_o       (fault_id_o),
        .irq_req_o        (irq_req_o),
        .fatal_o          (fatal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3*CW-1:0] cnt;
        logic [2:0]      faulty;
        logic [1:0]      id;
        logic            irq;
        logic            fatal;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: plain per-replica counts and a state number.
    int m_cnt[3];
    bit m_f[3];
    int m_st;
    int m_win;
    int m_id;
    bit m_irq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            m_cnt[k] = 0;
            m_f[k]   = 0;
        end
        m_st = ST_MON; m_win = 0; m_id = 0; m_irq = 0;
    endtask

    task automatic model_step(input bit rn, input bit clr, input bit vv, input bit [2:0] e, input bit ack);
        bit run, tick, unc, inc;
        int nnew, first;
        if (!rn || clr) begin
            model_clear();
            return;
        end
        run  = (m_st != ST_FAT);
        tick = run && (m_win == DW - 1);
        unc  = vv && (e == 3'b111);
        nnew = 0; first = 0;
        if (run) begin
            for (int k = 0; k < 3; k++) begin
                if (!m_f[k]) begin
                    inc = vv && e[k];
                    if (inc && !tick) m_cnt[k] = (m_cnt[k] < MAXC) ? m_cnt[k] + 1 : m_cnt[k];
                    else if (tick && !inc && m_cnt[k] > 0) m_cnt[k] = m_cnt[k] - 1;
                    if (m_cnt[k] >= TH) begin
                        m_f[k] = 1;
                        nnew++;
                        if (first == 0) first = k + 1;
                    end
                end
            end
        end
        if (m_irq && ack) m_irq = 0;
        case (m_st)
            ST_MON: begin
                if (unc || nnew >= 2) m_st = ST_FAT;
                else if (nnew == 1) begin m_st = ST_REP; m_id = first; m_irq = 1; end
            end
            ST_REP: begin
                if (unc || nnew > 0) m_st = ST_FAT;
                else if (ack) m_st = ST_DEG;
            end
            ST_DEG: begin
                if (nnew > 0) begin m_st = ST_FAT; m_id = first; m_irq = 1; end
                else if (unc) m_st = ST_FAT;
            end
            default: ;
        endcase
        if (run) m_win = (m_win + 1) % DW;
    endtask

    // Apply one cycle of inputs, predict, queue the prediction, advance.
    task automatic step(input bit rn, input bit clr, input bit vv, input bit [2:0] e, input bit ack);
        exp_t x;
        rst_n = rn; clear_i = clr; vote_valid_i = vv;
        err1 = e[0]; err2 = e[1]; err3 = e[2]; irq_ack_i = ack;
        model_step(rn, clr, vv, e, ack);
        for (int k = 0; k < 3; k++) x.cnt[k*CW +: CW] = m_cnt[k][CW-1:0];
        x.faulty = {m_f[2], m_f[1], m_f[0]};
        x.id     = m_id[1:0];
        x.irq    = m_irq;
        x.fatal  = (m_st == ST_FAT);
        q.push_back(x);
        @(posedge clk);
        #2;
    endtask

    task automatic idle_until_tick();
        for (int i = 0; i < 2 * DW && m_win != DW - 1; i++) step(1, 0, 0, 3'b000, 0);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_cnt"}, 32'(err_cnt_o), 0);
        chk({name, "_flags"}, {27'd0, faulty_o, fault_id_o, irq_req_o, fatal_o}, 0);
    endtask

    // Monitor: every cycle the DUT presents a new registered output word.
    always begin
        exp_t x;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            x = q.pop_front();
            chk("sb_err_cnt", 32'(err_cnt_o), 32'(x.cnt));
            chk("sb_faulty", 32'(faulty_o), 32'(x.faulty));
            chk("sb_fault_id", 32'(fault_id_o), 32'(x.id));
            chk("sb_irq_req", 32'(irq_req_o), 32'(x.irq));
            chk("sb_fatal", 32'(fatal_o), 32'(x.fatal));
        end
    end

    initial begin
        logic [3*CW-1:0] saved;
        bit [2:0] e;
        rst_n = 0; clear_i = 0; vote_valid_i = 0;
        err1 = 0; err2 = 0; err3 = 0; irq_ack_i = 0;
        model_clear();
        @(posedge clk);
        #2;

        // Reset with inputs toggling
        for (int i = 0; i < 2; i++) step(0, 1'($urandom), 1, 3'($urandom), 1'($urandom));
        chk_all_zero("reset");
        step(1, 0, 0, 3'b000, 0);
        chk_all_zero("release");

        // Threshold and report on replica 2
        repeat (4) step(1, 0, 1, 3'b010, 0);
        chk("thr_cnt2", 32'(err_cnt_o[7:4]), 4);
        chk("thr_faulty", 32'(faulty_o), 32'b010);
        chk("thr_id", 32'(fault_id_o), 2);
        chk("thr_irq", 32'(irq_req_o), 1);
        step(1, 0, 0, 3'b000, 0);
        step(1, 0, 0, 3'b000, 0);
        step(1, 0, 0, 3'b000, 1);
        chk("ack_irq", 32'(irq_req_o), 0);
        repeat (3) step(1, 0, 1, 3'b010, 0);
        chk("frozen_cnt2", 32'(err_cnt_o[7:4]), 4);

        // Decay and net-zero on replica 1
        step(1, 1, 1, 3'b111, 0);
        chk_all_zero("clear1");
        repeat (2) step(1, 0, 1, 3'b001, 0);
        chk("dec_pre", 32'(err_cnt_o[3:0]), 2);
        idle_until_tick();
        step(1, 0, 0, 3'b000, 0);
        chk("dec_post", 32'(err_cnt_o[3:0]), 1);
        idle_until_tick();
        step(1, 0, 1, 3'b001, 0);
        chk("net_zero", 32'(err_cnt_o[3:0]), 1);

        // Uncorrectable in MONITOR
        step(1, 0, 1, 3'b111, 0);
        chk("unc_fatal", 32'(fatal_o), 1);
        saved = err_cnt_o;
        for (int i = 0; i < 10; i++) step(1, 0, 1, 3'($urandom), 1'($urandom));
        chk("unc_sticky", 32'(fatal_o), 1);
        chk("unc_frozen", 32'(err_cnt_o), 32'(saved));
        step(1, 1, 0, 3'b000, 0);
        chk_all_zero("clear2");

        // Simultaneous failure of replicas 1 and 3
        repeat (3) step(1, 0, 1, 3'b101, 0);
        chk("sim_pre", 32'(err_cnt_o), 32'h303);
        step(1, 0, 1, 3'b101, 0);
        chk("sim_faulty", 32'(faulty_o), 32'b101);
        chk("sim_fatal", 32'(fatal_o), 1);
        chk("sim_irq", 32'(irq_req_o), 0);
        step(1, 1, 0, 3'b000, 0);

        // Second fault while degraded
        repeat (4) step(1, 0, 1, 3'b100, 0);
        chk("deg_id3", 32'(fault_id_o), 3);
        step(1, 0, 0, 3'b000, 1);
        chk("deg_ack", 32'(irq_req_o), 0);
        for (int i = 0; i < 20 && !m_f[0]; i++) step(1, 0, 1, 3'b001, 0);
        chk("deg_fatal", 32'(fatal_o), 1);
        chk("deg_id1", 32'(fault_id_o), 1);
        chk("deg_irq", 32'(irq_req_o), 1);
        step(0, 0, 1, 3'b111, 0);
        chk_all_zero("mid_rst");
        step(1, 0, 0, 3'b000, 0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < 3; k++) e[k] = ($urandom_range(0, 99) < 30);
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 3) != 0), e, ($urandom_range(0, 2) == 0));
        end

        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        #3;
        chk("sb_drain", 32'(q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
